core_sequencer: RTL

Multi-cycle control sequencer for the RV32i core. It owns the PC and the instruction register, and steps each instruction through fetch, decode, execute, memory and write-back. It drives the instruction-memory and data-memory request/acknowledge handshakes, and gates the register-file write strobe from the combinational decoder's reg_r/is_load_store/mem_w flags. It sits between the memory ports and the decoder/execution unit.

---
 rtl/core_sequencer_pkg.sv | 39 +++
 rtl/core_seq_waitcnt.sv | 36 +++
 rtl/core_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the core_sequencer slice.
// CORE_SEQ_TRAP_EN adds the TRAP state.
package core_sequencer_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;

  localparam logic [MEM_DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WB,
    ST_ERR
`ifdef CORE_SEQ_TRAP_EN
    , ST_TRAP
`endif
  } seq_state_e;

  // STORE is included so that mem_w_i has an instruction that can use it.
  function automatic logic opcode_supported(input logic [6:0] op);
    case (op)
      OPCODE_LUI, OPCODE_AUIPC, OPCODE_LOAD,
      OPCODE_STORE, OPCODE_OP_IMM, OPCODE_OP: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_waitcnt.sv
// Bus wait counter with timeout compare, shared by the fetch and data ports.
// MAX_WAIT = 0 disables the timeout.
module core_seq_waitcnt #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i) begin
      cnt_d = '0;
    end else if (!ack_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires in the cycle whose wait would make the count reach MAX_WAIT; an ack always wins.
  assign timeout_o = (MAX_WAIT != 0) && req_i && !ack_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/write-back sequencer for the RV32i core.
// Define CORE_SEQ_TRAP_EN to trap unsupported opcodes instead of retiring them as NOPs.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned               MAX_WAIT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      halt_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                      imem_ack_i,
  input  logic [MEM_DATA_WIDTH-1:0] imem_rdata_i,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] pc_o,
  input  logic                      is_load_store_i,
  input  logic                      mem_w_i,
  input  logic                      reg_r_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  input  logic                      dmem_ack_i,
  output logic                      reg_we_o,
  output logic                      retire_o,
  output logic                      err_o,
  output logic                      trap_o
);

  localparam logic [MEM_ADDR_WIDTH-1:0] PC_INIT = {RESET_PC[MEM_ADDR_WIDTH-1:2], 2'b00};

  seq_state_e                state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [MEM_DATA_WIDTH-1:0] instr_q, instr_d;
  logic                      op_ok;
  logic                      bus_req, bus_ack, timeout;

  assign op_ok   = opcode_supported(instr_q[6:0]);
  assign bus_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign bus_ack = ((state_q == ST_FETCH) && imem_ack_i) ||
                   ((state_q == ST_MEM)   && dmem_ack_i);

  core_seq_waitcnt #(.MAX_WAIT(MAX_WAIT)) u_waitcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus_req),
    .ack_i     (bus_ack),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= PC_INIT;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE:    if (!halt_i) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
`ifdef CORE_SEQ_TRAP_EN
        if (!op_ok)                     state_d = ST_TRAP;
        else if (is_load_store_i)       state_d = ST_MEM;
        else                            state_d = ST_WB;
`else
        if (op_ok && is_load_store_i)   state_d = ST_MEM;
        else                            state_d = ST_WB;
`endif
      end
      ST_MEM: begin
        if (dmem_ack_i)   state_d = ST_WB;
        else if (timeout) state_d = ST_ERR;
      end
      ST_WB: begin
        pc_d    = pc_q + MEM_ADDR_WIDTH'(4);
        state_d = halt_i ? ST_IDLE : ST_FETCH;
      end
      ST_ERR:     state_d = ST_ERR;
`ifdef CORE_SEQ_TRAP_EN
      ST_TRAP:    state_d = ST_TRAP;
`endif
      default:    state_d = ST_ERR;
    endcase
  end

  // Requests are qualified with rst_n so they read 0 while reset is held even though
  // the reset state is FETCH.
  always_comb begin
    imem_req_o = rst_n && (state_q == ST_FETCH);
    dmem_req_o = rst_n && (state_q == ST_MEM);
    dmem_we_o  = rst_n && (state_q == ST_MEM) && mem_w_i;
    reg_we_o   = (state_q == ST_WB) && reg_r_i && !mem_w_i && op_ok;
    retire_o   = (state_q == ST_WB);
    err_o      = (state_q == ST_ERR);
`ifdef CORE_SEQ_TRAP_EN
    trap_o     = (state_q == ST_TRAP);
`else
    trap_o     = 1'b0;
`endif
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;

endmodule
